rtc_read_sequencer: RTL and testbench

//  Sequences periodic read sweeps of the RTC time/date/timer registers into the data-direction register bank.
//  - For each register: one bus read transaction on the req/ack handshake, then the matching one-cycle en_* strobe.
//  - The en_* strobe makes the bank capture the byte on its shared 8-bit entrada bus.
//  - Sits between the RTC bus driver and the register bank; the bank is its only consumer.

---
 rtl/rtc_read_sequencer_if.sv | 9 +
 rtl/rtc_read_sequencer.sv | 156 +++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_read_sequencer_if.sv
// Read-request handshake between the sweep sequencer (master) and the RTC bus driver (slave).
interface rtc_read_sequencer_if;
    logic       req;
    logic [7:0] addr;
    logic       ack;

    modport master (output req, output addr, input ack);
    modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/rtc_read_sequencer.sv
// Periodic RTC register read sweep: one bus read per register, then its one-cycle capture strobe.
// Optional feature macro RTC_SEQ_TIMER_SWEEP_EN adds the three timer registers to every sweep.
module rtc_read_sequencer #(
    parameter logic [7:0] ADDR_CLK_BASE  = 8'h21,
    parameter logic [7:0] ADDR_TIM_BASE  = 8'h41,
    parameter int         REFRESH_CYCLES = 100_000_000,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    rtc_read_sequencer_if.master bus,
    output logic                 en_seg,
    output logic                 en_min,
    output logic                 en_hora,
    output logic                 en_dia,
    output logic                 en_mes,
    output logic                 en_anio,
    output logic                 en_seg_tim,
    output logic                 en_min_tim,
    output logic                 en_hora_tim,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

`ifdef RTC_SEQ_TIMER_SWEEP_EN
    localparam int NREG = 9;
`else
    localparam int NREG = 6;
`endif
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STROBE, SKIP, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        idx;
    logic [TW-1:0]     tcnt;
    logic [RW-1:0]     rcnt;
    logic              pending;
    logic              error_q;
    logic              wrap;
    logic              go;
    logic              tfire;
    logic              last;
    logic              req_int;
    logic [7:0]        cur_addr;
    logic [NREG-1:0]   en_vec;

    assign wrap  = (rcnt == RW'(REFRESH_CYCLES - 1));
    assign go    = (state == IDLE) && !hold && (pending || start || wrap);
    assign tfire = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign last  = (idx == 4'(NREG - 1));

    // Clock/date registers sit at consecutive addresses, timer registers in a second block.
    always_comb begin
        cur_addr = ADDR_CLK_BASE + {4'd0, idx};
        if (idx >= 4'd6)
            cur_addr = ADDR_TIM_BASE + {4'd0, idx - 4'd6};
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        req_int  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        en_vec   = '0;
        case (state)
            IDLE: begin
                if (go)
                    state_nx = REQ;
            end
            REQ, WAIT: begin
                req_int = 1'b1;
                busy    = 1'b1;
                if (bus.ack)
                    state_nx = STROBE;
                else if (tfire)
                    state_nx = SKIP;
                else
                    state_nx = WAIT;
            end
            STROBE: begin
                busy     = 1'b1;
                en_vec   = NREG'(1) << idx;
                state_nx = last ? DONE : REQ;
            end
            SKIP: begin
                busy     = 1'b1;
                state_nx = last ? DONE : REQ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A start or refresh wrap arriving while busy or held is remembered as a single pending sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            tcnt    <= '0;
            rcnt    <= '0;
            pending <= 1'b0;
            error_q <= 1'b0;
        end else begin
            rcnt    <= wrap ? '0 : rcnt + RW'(1);
            pending <= go ? 1'b0 : (pending || start || wrap);
            if (state == REQ || state == WAIT)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (state == IDLE)
                idx <= '0;
            else if (state == STROBE || state == SKIP)
                idx <= idx + 4'd1;
            if (go)
                error_q <= 1'b0;
            else if (state_nx == SKIP)
                error_q <= 1'b1;
        end
    end

    assign bus.req  = req_int;
    assign bus.addr = req_int ? cur_addr : 8'h00;
    assign error    = error_q;

    assign en_seg  = en_vec[0];
    assign en_min  = en_vec[1];
    assign en_hora = en_vec[2];
    assign en_dia  = en_vec[3];
    assign en_mes  = en_vec[4];
    assign en_anio = en_vec[5];
`ifdef RTC_SEQ_TIMER_SWEEP_EN
    assign en_seg_tim  = en_vec[6];
    assign en_min_tim  = en_vec[7];
    assign en_hora_tim = en_vec[8];
`else
    assign en_seg_tim  = 1'b0;
    assign en_min_tim  = 1'b0;
    assign en_hora_tim = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Self-checking bench: timeline reference model of the sweep plus directed literal checks.
module tb_rtc_read_sequencer;

    localparam int REFRESH = 50;
    localparam int TIMEOUT = 4;
`ifdef RTC_SEQ_TIMER_SWEEP_EN
    localparam int NREG = 9;
`else
    localparam int NREG = 6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, hold, bank_clr;
    logic [7:0] entrada;
    logic       en_seg, en_min, en_hora, en_dia, en_mes, en_anio;
    logic       en_seg_tim, en_min_tim, en_hora_tim;
    logic       busy, done, error;
    logic [8:0] dut_en;

    rtc_read_sequencer_if bus ();

    rtc_read_sequencer #(
        .ADDR_CLK_BASE (8'h21),
        .ADDR_TIM_BASE (8'h41),
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .bus(bus),
        .en_seg(en_seg), .en_min(en_min), .en_hora(en_hora), .en_dia(en_dia),
        .en_mes(en_mes), .en_anio(en_anio), .en_seg_tim(en_seg_tim),
        .en_min_tim(en_min_tim), .en_hora_tim(en_hora_tim),
        .busy(busy), .done(done), .error(error)
    );

    assign dut_en = {en_hora_tim, en_min_tim, en_seg_tim, en_anio, en_mes,
                     en_dia, en_hora, en_min, en_seg};

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    int ack_mode = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic r);
        start = s;
        hold  = h;
        reset = r;
        @(negedge clk);
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return (i < 6) ? 8'h21 + 8'(i) : 8'h41 + 8'(i - 6);
    endfunction

    // ---------------- reference model: timeline of one sweep ----------------
    logic       e_req, e_busy, e_done, e_error;
    logic [7:0] e_addr;
    logic [8:0] e_en;
    int         m_t;
    bit         m_pend, s_rst, s_ack, s_hold;

    task automatic m_tick();
        @(posedge clk);
        s_rst  = reset;
        s_ack  = bus.ack;
        s_hold = hold;
        if (reset) begin
            m_t    = 0;
            m_pend = 0;
        end else begin
            if (start || (m_t % REFRESH == REFRESH - 1))
                m_pend = 1;
            m_t++;
        end
    endtask

    task automatic m_sweep(output bit aborted);
        bit acked;
        aborted = 0;
        e_error = 0;
        e_busy  = 1;
        for (int i = 0; i < NREG; i++) begin
            acked  = 0;
            e_req  = 1;
            e_addr = addr_of(i);
            e_en   = '0;
            for (int c = 0; c < TIMEOUT; c++) begin
                m_tick();
                if (s_rst) begin aborted = 1; return; end
                if (s_ack) begin acked = 1; break; end
            end
            e_req  = 0;
            e_addr = 8'h00;
            if (acked) e_en = 9'(1) << i;
            else       e_error = 1;
            m_tick();
            if (s_rst) begin aborted = 1; return; end
            e_en = '0;
        end
        e_busy = 0;
        e_done = 1;
        m_tick();
        if (s_rst) begin aborted = 1; return; end
        e_done = 0;
    endtask

    initial begin
        bit ab;
        m_t = 0; m_pend = 0; e_error = 0;
        forever begin
            e_req = 0; e_addr = 8'h00; e_en = '0; e_busy = 0; e_done = 0;
            m_tick();
            if (s_rst) begin
                e_error = 0;
            end else if (m_pend && !s_hold) begin
                m_pend = 0;
                m_sweep(ab);
                if (ab) e_error = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            checkOutput("req", bus.req, e_req);
            if (e_req) checkOutput("addr", bus.addr, e_addr);
            checkOutput("en", dut_en, e_en);
            checkOutput("busy", busy, e_busy);
            checkOutput("done", done, e_done);
            checkOutput("error", error, e_error);
        end
    end

    // ---------------- bus driver / responder ----------------
    initial begin
        int  rh, target;
        bit  ack_v, prev_ack;
        rh = 0; target = 0; prev_ack = 0;
        bus.ack = 1'b0;
        entrada = 8'hFF;
        forever begin
            @(negedge clk);
            rh = bus.req ? rh + 1 : 0;
            if (bus.req && rh == 1) begin
                case (ack_mode)
                    1:       target = (bus.addr == 8'h23) ? 0 : 4;
                    2:       target = $urandom_range(1, 6);
                    default: target = 4;
                endcase
            end
            ack_v = bus.req && (rh == target);
            if (ack_mode == 2 && !bus.req && $urandom_range(0, 7) == 0)
                ack_v = 1;
            entrada  = prev_ack ? 8'h77 : 8'hFF;
            prev_ack = ack_v;
            bus.ack  = ack_v;
        end
    end

    logic [7:0] sal [9];
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 9; i++) sal[i] <= 8'h00;
        end else begin
            if (en_seg)      sal[0] <= entrada;
            if (en_min)      sal[1] <= entrada;
            if (en_hora)     sal[2] <= entrada;
            if (en_dia)      sal[3] <= entrada;
            if (en_mes)      sal[4] <= entrada;
            if (en_anio)     sal[5] <= entrada;
            if (en_seg_tim)  sal[6] <= entrada;
            if (en_min_tim)  sal[7] <= entrada;
            if (en_hora_tim) sal[8] <= entrada;
        end
    end

    // Per-sweep record of request addresses, request lengths and hora strobes.
    logic [7:0] addr_q [$];
    int         len_q  [$];
    int         hora_cnt = 0;
    initial begin
        bit busy_prev, req_prev;
        int cur_len;
        busy_prev = 0; req_prev = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && !busy_prev) begin
                addr_q.delete();
                len_q.delete();
                hora_cnt = 0;
            end
            if (bus.req === 1'b1 && !req_prev) begin
                addr_q.push_back(bus.addr);
                cur_len = 1;
            end else if (bus.req === 1'b1) begin
                cur_len++;
            end else if (req_prev) begin
                len_q.push_back(cur_len);
            end
            if (en_hora === 1'b1) hora_cnt++;
            busy_prev = (busy === 1'b1);
            req_prev  = (bus.req === 1'b1);
        end
    end

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1; break; end
        end
        checkOutput("done_seen", 32'(ok), 1);
    endtask

    task automatic wait_busy(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin ok = 1; break; end
        end
        checkOutput("busy_seen", 32'(ok), 1);
    endtask

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        int  req_cnt, n24;
        bit  found, hold_r;
        reset = 1'b1; start = 1'b0; hold = 1'b0; bank_clr = 1'b1;
        repeat (10) @(negedge clk);
        check_en = 1'b1;
        checkOutput("rst_req", bus.req, 0);
        checkOutput("rst_addr", bus.addr, 8'h00);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        bank_clr = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_req", bus.req, 1);
        checkOutput("t1_addr", bus.addr, 8'h21);
        checkOutput("t1_busy", busy, 1);
        start = 1'b0;
        wait_done(300);
        checkOutput("t1_nreq", addr_q.size(), NREG);
        for (int i = 0; i < NREG; i++) begin
            logic [7:0] want [9];
            want = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
            checkOutput($sformatf("t1_addr%0d", i), addr_q[i], want[i]);
            checkOutput($sformatf("t2_sal%0d", i), sal[i], 8'h77);
        end

        ack_mode = 1;
        wait_done(300);
        checkOutput("t3_addr_hora", addr_q[2], 8'h23);
        checkOutput("t3_len_hora", len_q[2], 4);
        checkOutput("t3_next_addr", addr_q[3], 8'h24);
        checkOutput("t3_no_en_hora", hora_cnt, 0);
        checkOutput("t3_error", error, 1);

        wait_busy(200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300);
        checkOutput("t5_error_last", error, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_busy", busy, 1);
        checkOutput("t5_error_clr", error, 0);
        checkOutput("t5_addr", bus.addr, 8'h21);
        ack_mode = 0;

        wait_done(300);
        hold = 1'b1;
        req_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.req === 1'b1) req_cnt++;
        end
        checkOutput("t4_no_req_hold", req_cnt, 0);
        hold = 1'b0;
        checkOutput("t4_req_at_fall", bus.req, 0);
        @(negedge clk);
        checkOutput("t4_req_after", bus.req, 1);
        checkOutput("t4_addr_after", bus.addr, 8'h21);

        found = 0; n24 = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            n24 = (bus.req === 1'b1 && bus.addr == 8'h24) ? n24 + 1 : 0;
            if (n24 >= 2) found = 1;
        end
        checkOutput("t6_wait_found", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_req", bus.req, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_en", dut_en, 9'h000);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checkOutput("t6_restart_req", bus.req, 1);
        checkOutput("t6_restart_addr", bus.addr, 8'h21);
        start = 1'b0;

        ack_mode = 2;
        hold_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) hold_r = !hold_r;
            applyStimulus($urandom_range(0, 39) == 0, hold_r, $urandom_range(0, 799) == 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
